load_unit: RTL and testbench
============================

Name: load_unit

Overview:
- Data-memory read path of the core; the read-side counterpart of the store unit.
- Computes the effective address rs1+imm and issues a byte-enabled read to data memory.
- Waits for read data under a valid handshake, then extracts, sign- or zero-extends and writes back to the register file.
- Stalls the PC for the whole access, then flags the re-presented instruction as ignorable on the write-back cycle, using the same protocol as the store unit.

Parameters:
- TIMEOUT_CYCLES, 255: maximum WAIT cycles without mem_rvalid before abort.
- MISALIGN_CHECK, 1: 1 = misaligned LH/LHU/LW is trapped; 0 = address is forced aligned by clearing low bits.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, asynchronous, active-high
- rs1_val  in  32  base register value
- imm  in  32  sign-extended offset
- load_control  in  3  0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU; 6/7 treated as none
- rd_addr  in  5  destination register
- mem_rdata  in  32  read data word
- mem_rvalid  in  1  read data valid
- stall_pc  out  1  hold PC
- ignore_curr_inst  out  1  current decoded instruction already completed
- mem_rw_mode  out  1  1 read, 0 write; this block only drives 1
- mem_req  out  1  read request
- mem_addr  out  32  byte address
- mem_byte_en  out  4  lanes read
- rd_wr_en  out  1  register-file write strobe
- rd_wr_addr  out  5  write-back register
- rd_wr_data  out  32  write-back data
- load_err  out  1  one-cycle pulse on misalign or timeout

Behaviour:
- Reset (async, while i_rst=1):
  - State goes to IDLE; counter and latches clear.
  - All outputs 0 except mem_rw_mode=1.
  - Reset mid-access drops mem_req immediately; no write-back occurs.
- State IDLE:
  - stall_pc is combinational: 1 iff load_control is valid (1–5); ignore_curr_inst=0; mem_req=0.
  - On a clock edge with a valid load, latch addr=rs1_val+imm (mod 2^32), type and rd_addr.
  - If misaligned and MISALIGN_CHECK=1 (LH/LHU with addr[0]=1, or LW with addr[1:0]!=0): go to DONE with err flag set.
  - Otherwise go to WAIT.
  - mem_rvalid is ignored in IDLE.
- State WAIT:
  - Registered outputs: mem_req=1, stall_pc=1, mem_addr=latched addr.
  - mem_byte_en: byte → 1<<addr[1:0]; half → 0011 if addr[1]=0, else 1100; word → 1111.
  - Inputs load_control, rs1_val and imm are ignored.
  - Counter increments each cycle.
  - On mem_rvalid=1: capture the extracted result and go to DONE.
  - When the counter reaches TIMEOUT_CYCLES without rvalid: set err and go to DONE.
  - rvalid in the same cycle as the timeout: data wins, no error.
- Extraction:
  - Byte b = mem_rdata[8*addr[1:0] +: 8]; half h = mem_rdata[16*addr[1] +: 16].
  - LB = sext(b); LBU = zext(b); LH = sext(h); LHU = zext(h); LW = mem_rdata.
- State DONE (exactly one cycle):
  - stall_pc=0, ignore_curr_inst=1, mem_req=0.
  - rd_wr_en=1 iff no err and rd!=0; rd_wr_addr and rd_wr_data hold the latched values.
  - load_err=err.
  - Always returns to IDLE; a new load can start on the next cycle.
- Latency: aligned load with 1-cycle memory (rvalid the cycle after mem_req rises) gives a 3-cycle instruction (IDLE, WAIT, DONE).
- mem_addr, mem_byte_en and rd_wr_data are 0 when not in their active state.

Test Plan:
- LW rs1=0x100, imm=4, rvalid 1 cycle after req, rdata=0xDEADBEEF, rd=5 → mem_addr=0x104, byte_en=1111, DONE writes x5=0xDEADBEEF, stall_pc high for 2 cycles.
- LB addr=0x103, rdata=0x80_00_00_00 → byte_en=1000, rd_wr_data=0xFFFFFF80; same with LBU → 0x00000080.
- LH addr=0x202 rdata=0x8001_1234 → byte_en=1100, data 0xFFFF8001; LHU → 0x00008001.
- LW addr=0x101, MISALIGN_CHECK=1 → mem_req never asserts, load_err pulses 1 cycle, rd_wr_en=0, ignore_curr_inst=1.
- TIMEOUT_CYCLES=4, rvalid never → 4 WAIT cycles, then load_err=1, no write; repeat with rvalid on the 4th cycle → write occurs, load_err=0.
- Assert i_rst in WAIT → mem_req falls without a clock edge, no rd_wr_en; a load with rd=0 completes with rd_wr_en=0.

Source files
------------

// File: rtl/load_unit.sv
// Data-memory load path: computes rs1+imm, issues one byte-enabled read, extracts and writes back.
// 3 cycles with 1-cycle memory (IDLE, WAIT, DONE); holds the PC until rvalid or timeout, then a one-cycle DONE.
module load_unit #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter bit MISALIGN_CHECK = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] rs1_val,
    input  logic [31:0] imm,
    input  logic [2:0]  load_control,
    input  logic [4:0]  rd_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic        stall_pc,
    output logic        ignore_curr_inst,
    output logic        mem_rw_mode,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_byte_en,
    output logic        rd_wr_en,
    output logic [4:0]  rd_wr_addr,
    output logic [31:0] rd_wr_data,
    output logic        load_err
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [2:0] LC_LB  = 3'd1;
    localparam logic [2:0] LC_LH  = 3'd2;
    localparam logic [2:0] LC_LW  = 3'd3;
    localparam logic [2:0] LC_LBU = 3'd4;
    localparam logic [2:0] LC_LHU = 3'd5;

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [1:0]    state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [2:0]    type_q, type_d;
    logic [4:0]    rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [31:0]   data_q, data_d;

    logic        load_valid;
    logic [31:0] eff_addr;
    logic [31:0] aligned_addr;
    logic        is_half, is_word, misaligned;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] extracted;

    always_comb begin
        load_valid   = (load_control >= LC_LB) && (load_control <= LC_LHU);
        eff_addr     = rs1_val + imm;
        is_half      = (load_control == LC_LH) || (load_control == LC_LHU);
        is_word      = (load_control == LC_LW);
        misaligned   = (is_half && eff_addr[0]) || (is_word && (eff_addr[1:0] != 2'b00));
        aligned_addr = eff_addr;
        if (is_word) begin
            aligned_addr = {eff_addr[31:2], 2'b00};
        end else if (is_half) begin
            aligned_addr = {eff_addr[31:1], 1'b0};
        end
    end

    // Lane selection uses the latched address, so later changes on rs1/imm cannot disturb it.
    always_comb begin
        case (addr_q[1:0])
            2'd0:    byte_sel = mem_rdata[7:0];
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (type_q)
            LC_LB:   extracted = {{24{byte_sel[7]}}, byte_sel};
            LC_LBU:  extracted = {24'd0, byte_sel};
            LC_LH:   extracted = {{16{half_sel[15]}}, half_sel};
            LC_LHU:  extracted = {16'd0, half_sel};
            LC_LW:   extracted = mem_rdata;
            default: extracted = 32'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        type_d  = type_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (load_valid) begin
                    addr_d = MISALIGN_CHECK ? eff_addr : aligned_addr;
                    type_d = load_control;
                    rd_d   = rd_addr;
                    cnt_d  = '0;
                    data_d = 32'd0;
                    if (MISALIGN_CHECK && misaligned) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // Data arriving on the timeout cycle still completes the load cleanly.
                if (mem_rvalid) begin
                    data_d  = extracted;
                    state_d = ST_DONE;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            addr_q  <= 32'd0;
            type_q  <= 3'd0;
            rd_q    <= 5'd0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            data_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            type_q  <= type_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        stall_pc         = ((state_q == ST_IDLE) && load_valid && !i_rst) || (state_q == ST_WAIT);
        ignore_curr_inst = (state_q == ST_DONE);
        mem_rw_mode      = 1'b1;
        mem_req          = (state_q == ST_WAIT);
        mem_addr         = 32'd0;
        mem_byte_en      = 4'b0000;
        rd_wr_en         = 1'b0;
        rd_wr_addr       = 5'd0;
        rd_wr_data       = 32'd0;
        load_err         = 1'b0;
        if (state_q == ST_WAIT) begin
            mem_addr = addr_q;
            case (type_q)
                LC_LB, LC_LBU: mem_byte_en = 4'b0001 << addr_q[1:0];
                LC_LH, LC_LHU: mem_byte_en = addr_q[1] ? 4'b1100 : 4'b0011;
                LC_LW:         mem_byte_en = 4'b1111;
                default:       mem_byte_en = 4'b0000;
            endcase
        end
        if (state_q == ST_DONE) begin
            rd_wr_en   = !err_q && (rd_q != 5'd0);
            rd_wr_addr = rd_q;
            rd_wr_data = data_q;
            load_err   = err_q;
        end
    end
endmodule

// File: tb/tb_load_unit.sv
// Randomized bench for load_unit with a transaction-level reference model and per-cycle output compare.
module tb_load_unit;
    localparam int TMO = 4;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic [31:0] rs1_val = 32'd0;
    logic [31:0] imm = 32'd0;
    logic [2:0]  load_control = 3'd0;
    logic [4:0]  rd_addr = 5'd0;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_rvalid = 1'b0;
    logic        stall_pc, ignore_curr_inst, mem_rw_mode, mem_req;
    logic [31:0] mem_addr;
    logic [3:0]  mem_byte_en;
    logic        rd_wr_en;
    logic [4:0]  rd_wr_addr;
    logic [31:0] rd_wr_data;
    logic        load_err;

    load_unit #(.TIMEOUT_CYCLES(TMO), .MISALIGN_CHECK(1'b1)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .rs1_val(rs1_val), .imm(imm),
        .load_control(load_control), .rd_addr(rd_addr), .mem_rdata(mem_rdata),
        .mem_rvalid(mem_rvalid), .stall_pc(stall_pc), .ignore_curr_inst(ignore_curr_inst),
        .mem_rw_mode(mem_rw_mode), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_byte_en(mem_byte_en), .rd_wr_en(rd_wr_en), .rd_wr_addr(rd_wr_addr),
        .rd_wr_data(rd_wr_data), .load_err(load_err)
    );

    always #5 i_clk = ~i_clk;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    logic        e_stall, e_ign, e_req, e_wr_en, e_err;
    logic [31:0] e_addr, e_wr_data;
    logic [3:0]  e_be;
    logic [4:0]  e_wr_addr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    always @(negedge i_clk) begin
        if (chk_en) begin
            chk("stall_pc", 32'(stall_pc), 32'(e_stall));
            chk("ignore_curr_inst", 32'(ignore_curr_inst), 32'(e_ign));
            chk("mem_rw_mode", 32'(mem_rw_mode), 32'd1);
            chk("mem_req", 32'(mem_req), 32'(e_req));
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_byte_en", 32'(mem_byte_en), 32'(e_be));
            chk("rd_wr_en", 32'(rd_wr_en), 32'(e_wr_en));
            chk("rd_wr_addr", 32'(rd_wr_addr), 32'(e_wr_addr));
            chk("rd_wr_data", rd_wr_data, e_wr_data);
            chk("load_err", 32'(load_err), 32'(e_err));
        end
    end

    function automatic logic [31:0] ref_extract(input logic [2:0] lc, input logic [31:0] a,
                                                input logic [31:0] rdata);
        int unsigned b, h;
        b = (rdata >> (8 * int'(a[1:0]))) & 32'hFF;
        h = (rdata >> (16 * int'(a[1]))) & 32'hFFFF;
        case (lc)
            3'd1:    return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            3'd2:    return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            3'd3:    return rdata;
            3'd4:    return b;
            3'd5:    return h;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] lc, input logic [31:0] a);
        case (lc)
            3'd1, 3'd4: return 4'(1 << (a % 4));
            3'd2, 3'd5: return 4'(3 << (a & 2));
            3'd3:       return 4'hF;
            default:    return 4'h0;
        endcase
    endfunction

    task automatic clear_exp();
        e_stall = 0; e_ign = 0; e_req = 0; e_wr_en = 0; e_err = 0;
        e_addr = 0; e_wr_data = 0; e_be = 0; e_wr_addr = 0;
    endtask

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    // One instruction: rv_at is the WAIT cycle (1-based) carrying rvalid; beyond TMO means never.
    task automatic do_load(input logic [2:0] lc, input logic [31:0] rs1, input logic [31:0] im,
                           input logic [4:0] rd, input int rv_at, input logic [31:0] rdata);
        logic [31:0] a;
        bit valid, mis, ok;
        a     = rs1 + im;
        valid = (lc >= 1) && (lc <= 5);
        mis   = ((lc == 2 || lc == 5) && a[0]) || (lc == 3 && a[1:0] != 2'b00);
        ok    = 0;
        load_control = lc; rs1_val = rs1; imm = im; rd_addr = rd;
        mem_rvalid = 1'($urandom); mem_rdata = $urandom;
        clear_exp();
        e_stall = valid;
        cyc();
        if (!valid) return;
        if (!mis) begin
            for (int k = 1; k <= TMO; k++) begin
                load_control = 3'($urandom); rs1_val = $urandom; imm = $urandom; rd_addr = 5'($urandom);
                mem_rvalid = (k == rv_at);
                mem_rdata  = (k == rv_at) ? rdata : $urandom;
                clear_exp();
                e_stall = 1; e_req = 1; e_addr = a; e_be = ref_be(lc, a);
                cyc();
                if (k == rv_at) begin
                    ok = 1;
                    break;
                end
            end
        end
        load_control = lc; rs1_val = rs1; imm = im; rd_addr = rd;
        mem_rvalid = 1'($urandom); mem_rdata = $urandom;
        clear_exp();
        e_ign = 1; e_wr_en = ok && (rd != 0); e_wr_addr = rd;
        e_wr_data = ok ? ref_extract(lc, a, rdata) : 32'd0; e_err = !ok;
        cyc();
        mem_rvalid = 0;
    endtask

    initial begin
        logic [31:0] rs, im;
        clear_exp();
        chk("pin_lb", ref_extract(3'd1, 32'h103, 32'h8000_0000), 32'hFFFF_FF80);
        chk("pin_lbu", ref_extract(3'd4, 32'h103, 32'h8000_0000), 32'h0000_0080);
        chk("pin_lh", ref_extract(3'd2, 32'h202, 32'h8001_1234), 32'hFFFF_8001);
        chk("pin_lhu", ref_extract(3'd5, 32'h202, 32'h8001_1234), 32'h0000_8001);
        chk("pin_be_lb", 32'(ref_be(3'd1, 32'h103)), 32'h8);
        chk("pin_be_lh", 32'(ref_be(3'd2, 32'h202)), 32'hC);
        chk("pin_be_lw", 32'(ref_be(3'd3, 32'h104)), 32'hF);

        // Reset with a valid load presented: everything quiet except mem_rw_mode.
        load_control = 3'd3; rs1_val = 32'h100; mem_rvalid = 1'b1;
        #1 i_rst = 1'b1;
        @(posedge i_clk); #2;
        chk("rst_stall", 32'(stall_pc), 0);
        chk("rst_req", 32'(mem_req), 0);
        chk("rst_rw_mode", 32'(mem_rw_mode), 1);
        chk("rst_wr_en", 32'(rd_wr_en), 0);
        chk("rst_ign", 32'(ignore_curr_inst), 0);
        chk("rst_addr", mem_addr, 0);
        @(posedge i_clk); #1;
        i_rst = 1'b0; load_control = 3'd0; mem_rvalid = 1'b0;
        chk_en = 1'b1;

        do_load(3'd3, 32'h100, 32'd4, 5'd5, 1, 32'hDEAD_BEEF);
        do_load(3'd1, 32'h100, 32'd3, 5'd7, 1, 32'h8000_0000);
        do_load(3'd4, 32'h100, 32'd3, 5'd7, 2, 32'h8000_0000);
        do_load(3'd2, 32'h200, 32'd2, 5'd8, 1, 32'h8001_1234);
        do_load(3'd5, 32'h200, 32'd2, 5'd8, 3, 32'h8001_1234);
        do_load(3'd3, 32'h100, 32'd1, 5'd9, 1, 32'h1111_2222);
        do_load(3'd3, 32'h300, 32'd0, 5'd10, 99, 32'h0);
        do_load(3'd3, 32'h300, 32'd0, 5'd10, TMO, 32'h5555_AAAA);
        do_load(3'd3, 32'h300, 32'd8, 5'd0, 1, 32'h1234_5678);
        do_load(3'd6, 32'h300, 32'd8, 5'd3, 1, 32'h1234_5678);
        do_load(3'd7, 32'h300, 32'd8, 5'd3, 1, 32'h1234_5678);
        do_load(3'd0, 32'h300, 32'd8, 5'd3, 1, 32'h1234_5678);

        // Reset in the middle of WAIT must drop mem_req without a clock edge.
        chk_en = 1'b0;
        load_control = 3'd3; rs1_val = 32'h40; imm = 32'd0; rd_addr = 5'd9; mem_rvalid = 1'b0;
        cyc();
        load_control = 3'd0;
        chk("mid_pre_req", 32'(mem_req), 1);
        #1 i_rst = 1'b1;
        #1;
        chk("mid_rst_req", 32'(mem_req), 0);
        chk("mid_rst_stall", 32'(stall_pc), 0);
        chk("mid_rst_wr_en", 32'(rd_wr_en), 0);
        cyc();
        i_rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        clear_exp();
        chk_en = 1'b1;
        cyc();
        mem_rvalid = 1'b0;
        cyc();

        for (int i = 0; i < 300; i++) begin
            rs = $urandom;
            im = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 64)) - 32'd32;
            if ($urandom_range(0, 1) == 1) begin
                rs = {rs[31:2], 2'b00};
                im = {im[31:2], 2'b00};
            end
            do_load(3'($urandom_range(0, 7)), rs, im, 5'($urandom), $urandom_range(1, 6), $urandom);
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
